// File: rtl/dram_arbiter.sv
// Two-client (VGA read / CPU read-write) arbiter in front of a single-command SDRAM controller port.
// One transaction in flight: IDLE arbitrates, ISSUE holds the command until accepted, WAIT_RD waits for read data.
module dram_arbiter #(
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 16
) (
    input  logic              CLK1_50,
    input  logic              RST,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_rvalid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

    localparam logic [1:0] GNT_NONE  = 2'b00;
    localparam logic [1:0] GNT_VGA   = 2'b01;
    localparam logic [1:0] GNT_CPU   = 2'b10;
    localparam logic [7:0] STARVE_TH = 8'(STARVE_LIMIT);

    state_t     state, state_nxt;
    logic [7:0] starve_cnt;
    logic       vga_win, cpu_win;

    assign mem_valid = (state == ISSUE);

    always_comb begin
        state_nxt = state;
        vga_win   = 1'b0;
        cpu_win   = 1'b0;
        case (state)
            IDLE: begin
                // VGA has priority until the CPU has waited long enough
                if (cpu_req && (!vga_req || starve_cnt >= STARVE_TH))
                    cpu_win = 1'b1;
                else if (vga_req)
                    vga_win = 1'b1;
                if (cpu_win || vga_win)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                if (mem_ready)
                    state_nxt = mem_we ? IDLE : WAIT_RD;
            end
            WAIT_RD: begin
                if (mem_rvalid)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK1_50 or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            starve_cnt <= 8'd0;
            grant      <= GNT_NONE;
            vga_ack    <= 1'b0;
            cpu_ack    <= 1'b0;
            vga_rvalid <= 1'b0;
            cpu_rvalid <= 1'b0;
            vga_rdata  <= '0;
            cpu_rdata  <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state      <= state_nxt;
            vga_ack    <= vga_win;
            cpu_ack    <= cpu_win;
            vga_rvalid <= 1'b0;
            cpu_rvalid <= 1'b0;

            if (vga_win || cpu_win) begin
                mem_addr  <= vga_win ? vga_addr : cpu_addr;
                mem_we    <= cpu_win & cpu_we;
                mem_wdata <= cpu_win ? cpu_wdata : '0;
                grant     <= vga_win ? GNT_VGA : GNT_CPU;
            end

            if (state == ISSUE && mem_ready && mem_we)
                grant <= GNT_NONE;

            // read data is steered to whoever owns the bus; the other client's rdata is untouched
            if (state == WAIT_RD && mem_rvalid) begin
                grant <= GNT_NONE;
                if (grant == GNT_VGA) begin
                    vga_rdata  <= mem_rdata;
                    vga_rvalid <= 1'b1;
                end else begin
                    cpu_rdata  <= mem_rdata;
                    cpu_rvalid <= 1'b1;
                end
            end

            if (!cpu_req || cpu_win)
                starve_cnt <= 8'd0;
            else if (grant != GNT_CPU && starve_cnt != 8'hFF)
                starve_cnt <= starve_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Scenario bench for dram_arbiter with a 3-cycle-latency memory model; read data = addr[15:0] ^ 16'h0F0F.
module tb_dram_arbiter;
    localparam int AW = 24;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          vga_req, vga_ack, vga_rvalid;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_rdata;
    logic          cpu_req, cpu_we, cpu_ack, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          mem_valid, mem_we, mem_ready, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [1:0]    grant;

    int n_checks = 0;
    int n_pass   = 0;
    logic [DW-1:0] exp_q[$];
    logic [AW+DW-1:0] exp_wr_q[$];
    bit exp_who_q[$];

    int rd_cnt = 0;
    logic [DW-1:0] rd_pend = '0;

    dram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
        .CLK1_50(clk), .RST(rst),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack),
        .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .grant(grant)
    );

    always #5 clk = ~clk;

    // memory model: read data returns in the third cycle after command acceptance
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            #1;
            mem_rvalid = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rd_pend;
                end
            end
            if (mem_valid && mem_ready && !mem_we) begin
                rd_cnt  = 3;
                rd_pend = mem_addr[15:0] ^ 16'h0F0F;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        vga_req = 1'b1; vga_addr = 24'h000777;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 24'h000001; cpu_wdata = 16'h1111;
        mem_ready = 1'b1;
        cyc(3);
        n_checks++;
        if ({vga_ack, cpu_ack, vga_rvalid, cpu_rvalid, mem_valid, mem_we, grant} !== 8'h00)
            $display("FAIL rst_ctrl: got %b expected 00000000", {vga_ack, cpu_ack, vga_rvalid, cpu_rvalid, mem_valid, mem_we, grant});
        else n_pass++;
        n_checks++;
        if ({mem_addr, mem_wdata} !== '0) $display("FAIL rst_mem_fields: got %h expected 0", {mem_addr, mem_wdata});
        else n_pass++;
        n_checks++;
        if ({vga_rdata, cpu_rdata} !== '0) $display("FAIL rst_rdata: got %h expected 0", {vga_rdata, cpu_rdata});
        else n_pass++;
        vga_req = 1'b0;
        rst = 1'b0;
        cyc(1);
        n_checks++;
        if (cpu_ack !== 1'b1) $display("FAIL rst_first_arb: cpu_ack got %b expected 1", cpu_ack);
        else n_pass++;
        cpu_req = 1'b0;
        cyc(3);
    endtask

    task automatic test_cpu_write;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 24'h000123; cpu_wdata = 16'hBEEF; mem_ready = 1'b1;
        cyc(1);
        n_checks++;
        if ({cpu_ack, vga_ack} !== 2'b10) $display("FAIL wr_ack: got %b expected 10", {cpu_ack, vga_ack});
        else n_pass++;
        n_checks++;
        if (grant !== 2'b10) $display("FAIL wr_grant: got %b expected 10", grant);
        else n_pass++;
        n_checks++;
        if ({mem_valid, mem_we} !== 2'b11) $display("FAIL wr_valid_we: got %b expected 11", {mem_valid, mem_we});
        else n_pass++;
        n_checks++;
        if (mem_addr !== 24'h000123 || mem_wdata !== 16'hBEEF)
            $display("FAIL wr_fields: got %h/%h expected 000123/beef", mem_addr, mem_wdata);
        else n_pass++;
        cpu_req = 1'b0;
        cyc(1);
        n_checks++;
        if ({grant, mem_valid, cpu_ack} !== 4'b0000) $display("FAIL wr_done: got %b expected 0000", {grant, mem_valid, cpu_ack});
        else n_pass++;
        cyc(2);
    endtask

    task automatic test_vga_read;
        int wait_n;
        int cpu_rv_seen;
        bit got;
        logic [DW-1:0] exp;
        vga_req = 1'b1; vga_addr = 24'h005555; mem_ready = 1'b1;
        exp_q.push_back(16'h5A5A);
        cyc(1);
        n_checks++;
        if ({vga_ack, cpu_ack, grant} !== 4'b1001) $display("FAIL rd_ack_grant: got %b expected 1001", {vga_ack, cpu_ack, grant});
        else n_pass++;
        n_checks++;
        if ({mem_valid, mem_we} !== 2'b10 || mem_addr !== 24'h005555)
            $display("FAIL rd_cmd: got %b/%h expected 10/005555", {mem_valid, mem_we}, mem_addr);
        else n_pass++;
        vga_req = 1'b0;
        got = 0; wait_n = 0; cpu_rv_seen = 0;
        while (!got && wait_n < 20) begin
            cyc(1);
            wait_n++;
            if (cpu_rvalid) cpu_rv_seen++;
            if (vga_rvalid) got = 1;
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (!got) $display("FAIL rd_timeout: vga_rvalid got 0 expected 1 within 20 cycles");
        else n_pass++;
        if (got) begin
            n_checks++;
            if (vga_rdata !== exp) $display("FAIL rd_data: got %h expected %h", vga_rdata, exp);
            else n_pass++;
            n_checks++;
            if (wait_n !== 4) $display("FAIL rd_latency: got %0d expected 4", wait_n);
            else n_pass++;
        end
        cyc(1);
        n_checks++;
        if ({vga_rvalid, grant} !== 3'b000) $display("FAIL rd_pulse_end: got %b expected 000", {vga_rvalid, grant});
        else n_pass++;
        n_checks++;
        if (cpu_rv_seen !== 0 || cpu_rvalid !== 1'b0) $display("FAIL rd_cpu_quiet: got %0d expected 0", cpu_rv_seen);
        else n_pass++;
        cyc(2);
    endtask

    task automatic test_cpu_read;
        int wait_n;
        bit got;
        logic [DW-1:0] exp;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h00ABCD;
        exp_q.push_back(16'hA4C2);
        cyc(1);
        cpu_req = 1'b0;
        got = 0; wait_n = 0;
        while (!got && wait_n < 20) begin
            cyc(1);
            wait_n++;
            if (cpu_rvalid) got = 1;
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (!got || cpu_rdata !== exp) $display("FAIL cpu_rd_data: got %b/%h expected 1/%h", got, cpu_rdata, exp);
        else n_pass++;
        n_checks++;
        if (vga_rvalid !== 1'b0 || vga_rdata !== 16'h5A5A)
            $display("FAIL cpu_rd_vga_hold: got %b/%h expected 0/5a5a", vga_rvalid, vga_rdata);
        else n_pass++;
        cyc(3);
    endtask

    task automatic test_stall;
        int bad_fields;
        int bad_ack;
        mem_ready = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 24'h3FF00F; cpu_wdata = 16'h1234;
        cyc(1);
        n_checks++;
        if (cpu_ack !== 1'b1) $display("FAIL stall_ack: got %b expected 1", cpu_ack);
        else n_pass++;
        vga_req = 1'b1; vga_addr = 24'h000042;
        cpu_addr = 24'h000000; cpu_wdata = 16'h0000;
        bad_fields = 0; bad_ack = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (mem_valid !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 24'h3FF00F || mem_wdata !== 16'h1234)
                bad_fields++;
            if (vga_ack || cpu_ack) bad_ack++;
        end
        n_checks++;
        if (bad_fields !== 0) $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad_fields);
        else n_pass++;
        n_checks++;
        if (bad_ack !== 0) $display("FAIL stall_no_ack: got %0d acks expected 0", bad_ack);
        else n_pass++;
        mem_ready = 1'b1; cpu_req = 1'b0; vga_req = 1'b0;
        cyc(1);
        n_checks++;
        if ({grant, mem_valid} !== 3'b000) $display("FAIL stall_release: got %b expected 000", {grant, mem_valid});
        else n_pass++;
        cyc(2);
    endtask

    task automatic test_starve;
        int acks;
        int both;
        int cyc_n;
        bit who;
        for (int i = 0; i < 3; i++) begin
            exp_who_q.push_back(1'b0);
            exp_who_q.push_back(1'b1);
        end
        mem_ready = 1'b1;
        vga_req = 1'b1; vga_addr = 24'h000100;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 24'h000200; cpu_wdata = 16'h7777;
        acks = 0; both = 0; cyc_n = 0;
        while (acks < 6 && cyc_n < 80) begin
            cyc(1);
            cyc_n++;
            if (vga_ack && cpu_ack) both++;
            if (vga_ack || cpu_ack) begin
                who = cpu_ack;
                acks++;
                n_checks++;
                if (exp_who_q.size() == 0) $display("FAIL starve_order: unexpected ack %0d got cpu=%b", acks, who);
                else if (who !== exp_who_q.pop_front())
                    $display("FAIL starve_order: ack %0d got cpu=%b expected cpu=%b", acks, who, ~who);
                else n_pass++;
            end
        end
        vga_req = 1'b0; cpu_req = 1'b0;
        n_checks++;
        if (acks !== 6) $display("FAIL starve_count: got %0d acks expected 6", acks);
        else n_pass++;
        n_checks++;
        if (both !== 0) $display("FAIL starve_dual_ack: got %0d expected 0", both);
        else n_pass++;
        exp_who_q.delete();
        cyc(8);
    endtask

    task automatic test_back_to_back;
        int acks;
        int last_ack;
        int cyc_n;
        int gap_bad;
        logic [AW+DW-1:0] e;
        mem_ready = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 24'h000010; cpu_wdata = 16'hC000;
        exp_wr_q.push_back({24'h000010, 16'hC000});
        acks = 0; last_ack = 0; cyc_n = 0; gap_bad = 0;
        while (acks < 4 && cyc_n < 40) begin
            cyc(1);
            cyc_n++;
            if (mem_valid && mem_ready) begin
                e = exp_wr_q.pop_front();
                n_checks++;
                if ({mem_addr, mem_wdata} !== e) $display("FAIL b2b_cmd: got %h expected %h", {mem_addr, mem_wdata}, e);
                else n_pass++;
            end
            if (cpu_ack) begin
                acks++;
                if (acks > 1 && cyc_n - last_ack != 2) gap_bad++;
                last_ack = cyc_n;
                if (acks < 4) begin
                    cpu_addr  = cpu_addr + 24'd1;
                    cpu_wdata = cpu_wdata + 16'h0101;
                    exp_wr_q.push_back({cpu_addr, cpu_wdata});
                end else begin
                    cpu_req = 1'b0;
                end
            end
        end
        n_checks++;
        if (acks !== 4 || gap_bad !== 0) $display("FAIL b2b_rate: got %0d acks %0d bad gaps expected 4/0", acks, gap_bad);
        else n_pass++;
        exp_wr_q.delete();
        cyc(3);
    endtask

    task automatic test_reset_mid;
        int bad;
        mem_ready = 1'b1;
        vga_req = 1'b1; vga_addr = 24'h001234;
        cyc(1);
        vga_req = 1'b0;
        cyc(1);
        n_checks++;
        if (grant !== 2'b01) $display("FAIL rmid_in_wait: grant got %b expected 01", grant);
        else n_pass++;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (vga_rvalid || cpu_rvalid || vga_ack || cpu_ack || mem_valid || grant != 2'b00) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL rmid_quiet: got %0d active cycles expected 0", bad);
        else n_pass++;
        n_checks++;
        if ({vga_rdata, cpu_rdata, mem_addr, mem_wdata, mem_we} !== '0)
            $display("FAIL rmid_values: got %h expected 0", {vga_rdata, cpu_rdata, mem_addr, mem_wdata, mem_we});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_vga_read();
        test_cpu_read();
        test_stall();
        test_starve();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
